// File: rtl/port_stat_counter.sv
// Per-port event counter bank for the 4-port switch: one saturating or wrapping
// counter per port with a sticky overflow flag, read through a single-cycle req/ack port.
module port_stat_counter #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 16,
    parameter int SATURATE  = 1,
    localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [NUM_PORTS-1:0] inc,
    input  logic                 clear_all,
    input  logic                 rd_req,
    input  logic [PW-1:0]        rd_port,
    input  logic                 rd_clear,
    output logic                 rd_ack,
    output logic [WIDTH-1:0]     rd_data,
    output logic [NUM_PORTS-1:0] ovf
);

    localparam logic [WIDTH-1:0] FULL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0]     cnt_q [NUM_PORTS];
    logic [WIDTH-1:0]     cnt_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] ovf_q;
    logic [NUM_PORTS-1:0] ovf_d;
    logic                 rd_ack_q;
    logic                 rd_ack_d;
    logic [WIDTH-1:0]     rd_data_q;
    logic [WIDTH-1:0]     rd_data_d;
    logic [WIDTH-1:0]     rd_sel_s;

    // Next counter/overflow state per channel, highest-priority event first.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
            ovf_d[i] = ovf_q[i];
            if (clear_all) begin
                cnt_d[i] = ZERO;
                ovf_d[i] = 1'b0;
            end else if (rd_req && rd_clear && (rd_port == PW'(i))) begin
                // Clear-on-read keeps this cycle's increment so no event is lost.
                cnt_d[i] = (en && inc[i]) ? ONE : ZERO;
                ovf_d[i] = 1'b0;
            end else if (en && inc[i]) begin
                if (cnt_q[i] == FULL) begin
                    cnt_d[i] = (SATURATE != 0) ? FULL : ZERO;
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Read mux and capture; out-of-range channels return zero.
    always_comb begin
        rd_sel_s  = ZERO;
        rd_ack_d  = 1'b0;
        rd_data_d = rd_data_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_sel_s = (rd_port == PW'(i)) ? cnt_q[i] : rd_sel_s;
        end
        if (rd_req) begin
            rd_ack_d  = 1'b1;
            rd_data_d = rd_sel_s;
        end else begin
            rd_ack_d  = 1'b0;
            rd_data_d = rd_data_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= ZERO;
            end
            ovf_q     <= {NUM_PORTS{1'b0}};
            rd_ack_q  <= 1'b0;
            rd_data_q <= ZERO;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q     <= ovf_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_ack  = rd_ack_q;
    assign rd_data = rd_data_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_port_stat_counter.sv
// Scoreboard bench: three counter-bank configurations share one stimulus stream;
// reads push expected data per instance and per-instance monitors pop on rd_ack.
module tb_port_stat_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [3:0] inc = 4'b0000;
    logic       clear_all = 1'b0;
    logic       rd_req = 1'b0;
    logic [1:0] rd_port = 2'd0;
    logic       rd_clear = 1'b0;

    logic        ack_a, ack_b, ack_c;
    logic [15:0] data_a;
    logic [3:0]  data_b;
    logic [3:0]  data_c;
    logic [3:0]  ovf_a, ovf_b;
    logic [2:0]  ovf_c;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] q_c[$];

    always #5 clk = ~clk;

    // A: default 4 ports x 16 bits, saturating
    port_stat_counter #(.NUM_PORTS(4), .WIDTH(16), .SATURATE(1)) u_a (
        .clk(clk), .reset(reset), .en(en), .inc(inc), .clear_all(clear_all),
        .rd_req(rd_req), .rd_port(rd_port), .rd_clear(rd_clear),
        .rd_ack(ack_a), .rd_data(data_a), .ovf(ovf_a));

    // B: 4 ports x 4 bits, saturating
    port_stat_counter #(.NUM_PORTS(4), .WIDTH(4), .SATURATE(1)) u_b (
        .clk(clk), .reset(reset), .en(en), .inc(inc), .clear_all(clear_all),
        .rd_req(rd_req), .rd_port(rd_port), .rd_clear(rd_clear),
        .rd_ack(ack_b), .rd_data(data_b), .ovf(ovf_b));

    // C: 3 ports x 4 bits, wrapping; rd_port 3 is out of range
    port_stat_counter #(.NUM_PORTS(3), .WIDTH(4), .SATURATE(0)) u_c (
        .clk(clk), .reset(reset), .en(en), .inc(inc[2:0]), .clear_all(clear_all),
        .rd_req(rd_req), .rd_port(rd_port), .rd_clear(rd_clear),
        .rd_ack(ack_c), .rd_data(data_c), .ovf(ovf_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] p, input logic clr,
                      input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec);
        rd_req   = 1'b1;
        rd_port  = p;
        rd_clear = clr;
        q_a.push_back(ea);
        q_b.push_back(eb);
        q_c.push_back(ec);
        tick();
        rd_req   = 1'b0;
        rd_clear = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && ack_a) begin
            if (q_a.size() == 0) check("a_spurious_ack", 32'd1, 32'd0);
            else check("a_rd_data", 32'(data_a), q_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!reset && ack_b) begin
            if (q_b.size() == 0) check("b_spurious_ack", 32'd1, 32'd0);
            else check("b_rd_data", 32'(data_b), q_b.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!reset && ack_c) begin
            if (q_c.size() == 0) check("c_spurious_ack", 32'd1, 32'd0);
            else check("c_rd_data", 32'(data_c), q_c.pop_front());
        end
    end

    initial begin
        tick();
        tick();
        check("reset_ack", {29'd0, ack_a, ack_b, ack_c}, 32'd0);
        check("reset_data", 32'(data_a) | 32'(data_b) | 32'(data_c), 32'd0);
        check("reset_ovf", {21'd0, ovf_a, ovf_b, ovf_c}, 32'd0);
        reset = 1'b0;
        tick();

        // 10 increments on port 0, then en=0 with all strobes: no change
        en = 1'b1; inc = 4'b0001;
        repeat (10) tick();
        en = 1'b0; inc = 4'b1111;
        repeat (8) tick();
        inc = 4'b0000;
        rd(2'd0, 1'b0, 10, 10, 10);
        rd(2'd1, 1'b0, 0, 0, 0);
        rd(2'd2, 1'b0, 0, 0, 0);
        rd(2'd3, 1'b0, 0, 0, 0);
        tick();

        // 20 increments on port 2: 16-bit 20, 4-bit saturate 15, 4-bit wrap 4
        en = 1'b1; inc = 4'b0100;
        repeat (20) tick();
        en = 1'b0; inc = 4'b0000;
        check("ovf_a_after_20", 32'(ovf_a), 32'd0);
        check("ovf_b_after_20", 32'(ovf_b), 32'b0100);
        check("ovf_c_after_20", 32'(ovf_c), 32'b100);
        rd(2'd2, 1'b0, 20, 15, 4);
        rd(2'd0, 1'b0, 10, 10, 10);
        tick();
        tick();
        check("rd_ack_idle", {31'd0, ack_a}, 32'd0);
        check("rd_data_hold", 32'(data_a), 32'd10);

        // Port 1 to 7, clear-on-read with a coincident increment
        en = 1'b1; inc = 4'b0010;
        repeat (7) tick();
        rd(2'd1, 1'b1, 7, 7, 7);
        en = 1'b0; inc = 4'b0000;
        rd(2'd1, 1'b0, 1, 1, 1);
        rd(2'd2, 1'b1, 20, 15, 4);
        check("ovf_b_after_cor", 32'(ovf_b), 32'd0);
        check("ovf_c_after_cor", 32'(ovf_c), 32'd0);
        rd(2'd2, 1'b0, 0, 0, 0);
        tick();

        // Port 3 overflow on B, then clear_all clears flags
        en = 1'b1; inc = 4'b1000;
        repeat (16) tick();
        en = 1'b0; inc = 4'b0000;
        rd(2'd3, 1'b0, 16, 15, 0);
        check("ovf_b_port3", 32'(ovf_b), 32'b1000);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        check("ovf_after_clear_all", {21'd0, ovf_a, ovf_b, ovf_c}, 32'd0);

        // All counters to 5, then clear_all + read + increments together
        en = 1'b1; inc = 4'b1111;
        repeat (5) tick();
        clear_all = 1'b1;
        rd(2'd0, 1'b0, 5, 5, 5);
        clear_all = 1'b0; en = 1'b0; inc = 4'b0000;
        rd(2'd0, 1'b0, 0, 0, 0);
        rd(2'd1, 1'b0, 0, 0, 0);
        rd(2'd2, 1'b0, 0, 0, 0);
        rd(2'd3, 1'b0, 0, 0, 0);
        tick();
        check("ovf_after_coincident_clear", {21'd0, ovf_a, ovf_b, ovf_c}, 32'd0);

        // Reset asserted during the rd_ack cycle
        en = 1'b1; inc = 4'b0001;
        repeat (3) tick();
        en = 1'b0; inc = 4'b0000;
        rd_req = 1'b1; rd_port = 2'd0;
        tick();
        rd_req = 1'b0;
        check("pre_reset_ack", {29'd0, ack_a, ack_b, ack_c}, 32'b111);
        check("pre_reset_data_a", 32'(data_a), 32'd3);
        check("pre_reset_data_c", 32'(data_c), 32'd3);
        reset = 1'b1;
        #1;
        check("async_reset_ack", {29'd0, ack_a, ack_b, ack_c}, 32'd0);
        check("async_reset_data", 32'(data_a) | 32'(data_b) | 32'(data_c), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        rd(2'd0, 1'b0, 0, 0, 0);
        rd(2'd1, 1'b0, 0, 0, 0);
        tick();
        tick();

        check("q_a_drained", q_a.size(), 32'd0);
        check("q_b_drained", q_b.size(), 32'd0);
        check("q_c_drained", q_c.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/port_stat_counter.md
# port_stat_counter

Bank of per-port event counters for the 4-port switch: each port has an independent parametrised-width counter, advanced by single-cycle increment strobes from the port datapath. Counters are read one at a time through a single-cycle request/ack interface with optional clear-on-read. Each counter either saturates or wraps at full scale, selected by parameter, and has a sticky overflow flag. The block sits between the port MACs (event strobes) and the management/CSR logic (reads).

## Interface
- NUM_PORTS, 4, number of counter channels (1..16)
- WIDTH, 16, counter width in bits (2..32)
- SATURATE, 1, 1 = hold at 2^WIDTH-1 on overflow; 0 = wrap to 0
- PW, $clog2(NUM_PORTS) (min 1), width of rd_port; derived, not overridden
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  global count enable; inc ignored when 0
- inc  in  NUM_PORTS  per-port increment strobe, +1 per cycle when high
- clear_all  in  1  synchronous clear of all counters and overflow flags
- rd_req  in  1  read request, sampled every cycle
- rd_port  in  PW  channel index for rd_req
- rd_clear  in  1  with rd_req: clear selected channel after capture
- rd_ack  out  1  one-cycle pulse, rd_data valid
- rd_data  out  WIDTH  captured counter value
- ovf  out  NUM_PORTS  sticky overflow flag per channel

## Operation
- Reset: all counters 0, ovf 0, rd_ack 0, rd_data 0.
- Per channel i, each cycle, priority highest first:
  - clear_all=1: cnt[i] <= 0, ovf[i] <= 0; increments that cycle dropped.
  - rd_req=1, rd_clear=1, rd_port==i: cnt[i] <= (en & inc[i]) ? 1 : 0; ovf[i] <= 0. Same-cycle increment preserved.
  - en=1, inc[i]=1, cnt[i]==2^WIDTH-1: SATURATE=1 -> cnt holds; SATURATE=0 -> cnt <= 0. ovf[i] <= 1 in both modes.
  - en=1, inc[i]=1: cnt[i] <= cnt[i]+1.
  - else hold.
- ovf[i] stays set until clear_all, clear-on-read of channel i, or reset.
- Read capture: on a cycle with rd_req=1, rd_data <= cnt[rd_port] as held at that edge (before that cycle's increment/clear); rd_ack <= 1.
- clear_all coincident with rd_req: rd_data returns pre-clear value; clear_all wins for the counter.
- rd_port >= NUM_PORTS: rd_data <= 0, rd_ack <= 1, no counter or ovf affected.
- rd_data holds its last value when rd_ack=0.
- No busy state: rd_req accepted every cycle, back-to-back reads of any channels allowed.

## Timing
- Increment latency: inc at edge N visible in cnt (and in a read issued at edge N+1) from edge N+1.
- Read latency: rd_req sampled at edge N -> rd_ack=1, rd_data valid after edge N, for exactly one cycle per request.
- Back-to-back rd_req on cycles N, N+1 -> rd_ack high cycles N+1, N+2, each with its own data.
- ovf rises in the same cycle the counter reaches/holds the full-scale boundary event (edge of the overflowing increment).
- Reset asserted mid-read: rd_ack drops to 0 immediately (asynchronously); pending read is lost.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset then en=1, inc=4'b0001 for 10 cycles, read port 0 -> rd_ack one cycle later, rd_data=10; other ports read 0.
- WIDTH=4, SATURATE=1: 20 increments on port 2 -> read gives 15, ovf[2]=1; SATURATE=0 same stimulus -> read gives 4, ovf[2]=1.
- Counter at 7, rd_req+rd_clear on same cycle as inc -> rd_data=7, next read (no clear) returns 1, ovf cleared.
- clear_all coincident with rd_req and inc on all ports, counters at 5 -> rd_data=5, all counters 0 after, ovf=0.
- en=0 with inc=4'b1111 for 8 cycles -> all counters unchanged; back-to-back reads ports 0,1,2,3 -> four consecutive rd_ack pulses with correct per-port values.
- NUM_PORTS=3, read rd_port=3 -> rd_ack=1, rd_data=0, no counter changes; reset asserted during rd_ack cycle -> rd_ack and all counters 0 immediately.
